branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Downstream partner of the branch history table. Holds the prediction made at fetch for
//  each in-flight branch in a small in-order queue and checks it when EX resolves the branch.
//  Drives the BHT update port (en / write_addr / was_taken / jumped).
//  On a wrong prediction, raises a one-cycle pipeline flush and supplies the redirect PC.
// PARAMETERS
//  LOWER   5    BHT index width; index = pc[LOWER+1:2] (word-aligned PCs)
//  PC_W    64   program counter width
//  DEPTH   4    prediction queue entries (power of 2, >= 2)
// PORTS
//  clk              in   1       system clock, rising edge
//  arst_n           in   1       asynchronous active-low reset
//  fetch_valid      in   1       fetch issued a branch/jump with a prediction this cycle
//  fetch_pc         in   PC_W    PC of that instruction
//  fetch_pred       in   1       BHT prediction (1 = taken)
//  fetch_target     in   PC_W    predicted target used when fetch_pred = 1
//  q_full           out  1       queue full; fetch stalls while 1
//  ex_valid         in   1       EX resolves the oldest queued branch this cycle
//  ex_taken         in   1       conditional branch outcome
//  ex_jump          in   1       unconditional jump
//  ex_target        in   PC_W    computed target
//  bht_en           out  1       BHT update strobe
//  bht_write_addr   out  LOWER   BHT index to update
//  bht_was_taken    out  1       registered copy of ex_taken
//  bht_jumped       out  1       registered copy of ex_jump
//  flush            out  1       squash younger instructions (1-cycle pulse)
//  redirect_pc      out  PC_W    fetch restart PC, valid while flush = 1
//  mispredict_cnt   out  16      saturating count of mispredictions
//  underflow_err    out  1       sticky: ex_valid seen while queue was empty
// BEHAVIOUR
//  Reset (arst_n = 0, asynchronous):
//   - Queue is emptied; state = NORMAL.
//   - All outputs are 0. q_full = 0; redirect_pc = 0.
//  Queue entry: {pc, pred, target}. Order is in-order FIFO.
//   - Push: fetch_valid & ~q_full & state == NORMAL & ~mispredict_now.
//   - Pop: ex_valid & ~empty.
//   - Push and pop in the same cycle are both allowed, including when the queue is full
//     (q_full is evaluated before the pop). The count is then unchanged.
//   - A push while q_full = 1 is dropped. Fetch must hold the instruction.
//   - q_full is combinational from the occupancy count.
//  Resolution (pop cycle N; all results registered, visible in cycle N+1):
//   - actual = ex_taken | ex_jump.
//   - mispredict_now = (pred != actual) | (pred & actual & target != ex_target).
//   - bht_en = 1 for exactly 1 cycle; bht_write_addr = entry.pc[LOWER+1:2].
//     bht_was_taken = ex_taken; bht_jumped = ex_jump.
//   - If mispredict_now:
//     - flush = 1 for 1 cycle.
//     - redirect_pc = actual ? ex_target : entry.pc + 4.
//     - mispredict_cnt += 1, saturating at 16'hFFFF.
//     - All remaining queue entries (wrong-path) are discarded at the same edge.
//  FSM:
//   - NORMAL: on a pop with mispredict_now, go to RECOVER; otherwise stay.
//   - RECOVER: lasts 1 cycle (the cycle flush = 1). Pushes are blocked and ex_valid is
//     ignored. Then return to NORMAL.
//  ex_valid while empty (in NORMAL): no pop, no bht_en; set underflow_err (clears only on reset).
//  PC + 4 wraps modulo 2^PC_W.
//  Reset asserted mid-flush: flush drops immediately and the queue is emptied.
// STRUCTURE
//  Shared package:
//   - pred_entry_t struct {pc, pred, target}.
//   - state enum {NORMAL, RECOVER}.
//   - INSTR_BYTES = 4 and the BHT index slice helper.
//  Sub-module bru_pred_fifo:
//   - Circular buffer with DEPTH entries, read/write pointers and a count.
//   - Ports: push, pop, clear (clear has priority over push).
//  Top level: resolution compare, output registers, FSM, counters.
// TESTING
//  1. Reset, push pc=0x40 pred=0; EX resolves ex_taken=0 -> next cycle bht_en=1,
//     bht_write_addr=0x10, flush=0.
//  2. Push pc=0x40 pred=0; resolve ex_taken=1, target=0x80 -> flush=1 for 1 cycle,
//     redirect_pc=0x80, mispredict_cnt=1, queue empty.
//  3. Push pc=0x10 pred=1 target=0x20; resolve taken, ex_target=0x24 -> flush=1,
//     redirect_pc=0x24.
//  4. Push pred=1; resolve not taken -> redirect_pc = pc+4. Push 3 more entries before
//     resolving; all are discarded, and a push during RECOVER is dropped.
//  5. Fill 4 entries -> q_full=1 and a 5th push is dropped. Then push+pop in the same
//     cycle -> count stays 4 and order is preserved.
//  6. ex_valid with empty queue -> no bht_en, underflow_err=1; arst_n pulse mid-flush
//     -> all outputs 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch resolve unit and its prediction queue.
package branch_resolve_unit_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int BHT_LOWER   = 5;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_e;

  // One in-flight prediction as captured at fetch.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                pred;
    logic [PC_WIDTH-1:0] target;
  } pred_entry_t;

  // BHT index of a word-aligned PC.
  function automatic logic [BHT_LOWER-1:0] bht_index(input logic [PC_WIDTH-1:0] pc);
    return pc[BHT_LOWER+1:2];
  endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// In-order circular queue of fetch predictions (module bru_pred_fifo).
// clear wins over push; push/pop at the same time leave the count unchanged.
module bru_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        push,
  input  pred_entry_t wr_data,
  input  logic        pop,
  input  logic        clear,
  output pred_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pred_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic push_eff, pop_eff;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full queue only fits if the head leaves in the same cycle.
  assign push_eff = push & (~full | pop);
  assign pop_eff  = pop & ~empty;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; stale contents are never read because count gates the head.
  always_ff @(posedge clk) begin
    if (push_eff && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks each fetch prediction against the EX outcome, drives the BHT update
// port, and on a wrong prediction flushes the pipe and redirects fetch.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int LOWER = BHT_LOWER,
  parameter int PC_W  = PC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_pred,
  input  logic [PC_W-1:0]  fetch_target,
  output logic             q_full,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic             ex_jump,
  input  logic [PC_W-1:0]  ex_target,
  output logic             bht_en,
  output logic [LOWER-1:0] bht_write_addr,
  output logic             bht_was_taken,
  output logic             bht_jumped,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [15:0]      mispredict_cnt,
  output logic             underflow_err,
  output state_e           dbg_state
);

  // Handshake: fetch offers an entry with fetch_valid and it is taken in that
  // cycle when q_full = 0 (or when the head pops in the same cycle) and no
  // recovery is in progress; otherwise fetch holds it. ex_valid always refers
  // to the oldest queued entry and is accepted in the same cycle.

  state_e           state_q, state_d;
  logic             bht_en_q, bht_en_d;
  logic [LOWER-1:0] bht_write_addr_q, bht_write_addr_d;
  logic             bht_was_taken_q, bht_was_taken_d;
  logic             bht_jumped_q, bht_jumped_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [15:0]      mispredict_cnt_q, mispredict_cnt_d;
  logic             underflow_err_q, underflow_err_d;

  pred_entry_t head, new_entry;
  logic        empty, in_normal, pop, push, actual, mispredict_now;

  assign in_normal = (state_q == NORMAL);
  assign pop       = in_normal & ex_valid & ~empty;
  assign actual    = ex_taken | ex_jump;
  assign mispredict_now = pop & ((head.pred != actual) |
                                 (head.pred & actual & (head.target != ex_target)));
  assign push      = in_normal & fetch_valid & ~mispredict_now & (~q_full | pop);
  assign new_entry = '{pc: fetch_pc, pred: fetch_pred, target: fetch_target};

  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push    (push),
    .wr_data (new_entry),
    .pop     (pop),
    .clear   (mispredict_now),
    .rd_data (head),
    .full    (q_full),
    .empty   (empty)
  );

  // Resolution results, recovery FSM and counters for the next cycle.
  always_comb begin
    state_d          = state_q;
    bht_en_d         = 1'b0;
    bht_write_addr_d = bht_write_addr_q;
    bht_was_taken_d  = bht_was_taken_q;
    bht_jumped_d     = bht_jumped_q;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mispredict_cnt_d = mispredict_cnt_q;
    underflow_err_d  = underflow_err_q | (in_normal & ex_valid & empty);
    case (state_q)
      NORMAL: begin
        if (pop) begin
          bht_en_d         = 1'b1;
          bht_write_addr_d = bht_index(head.pc);
          bht_was_taken_d  = ex_taken;
          bht_jumped_d     = ex_jump;
        end
        if (mispredict_now) begin
          state_d       = RECOVER;
          flush_d       = 1'b1;
          redirect_pc_d = actual ? ex_target : head.pc + PC_W'(INSTR_BYTES);
          if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
      end
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Registered outputs and FSM state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q          <= NORMAL;
      bht_en_q         <= 1'b0;
      bht_write_addr_q <= '0;
      bht_was_taken_q  <= 1'b0;
      bht_jumped_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
      underflow_err_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      bht_en_q         <= bht_en_d;
      bht_write_addr_q <= bht_write_addr_d;
      bht_was_taken_q  <= bht_was_taken_d;
      bht_jumped_q     <= bht_jumped_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      underflow_err_q  <= underflow_err_d;
    end
  end

  assign bht_en         = bht_en_q;
  assign bht_write_addr = bht_write_addr_q;
  assign bht_was_taken  = bht_was_taken_q;
  assign bht_jumped     = bht_jumped_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign underflow_err  = underflow_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic,
// all checked against a queue-based model of the resolution rules.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int LOWER = 5;
  localparam int PC_W  = 64;
  localparam int DEPTH = 4;
  localparam int EW    = 2 * PC_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;

  logic             fetch_valid, fetch_pred;
  logic [PC_W-1:0]  fetch_pc, fetch_target;
  logic             q_full;
  logic             ex_valid, ex_taken, ex_jump;
  logic [PC_W-1:0]  ex_target;
  logic             bht_en, bht_was_taken, bht_jumped, flush, underflow_err;
  logic [LOWER-1:0] bht_write_addr;
  logic [PC_W-1:0]  redirect_pc;
  logic [15:0]      mispredict_cnt;
  state_e           dbg_state;

  branch_resolve_unit #(.LOWER(LOWER), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
    .fetch_target(fetch_target), .q_full(q_full),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_jump(ex_jump), .ex_target(ex_target),
    .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
    .bht_jumped(bht_jumped), .flush(flush), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt), .underflow_err(underflow_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0]    exp_q[$];   // {pc, pred, target}, oldest first
  bit               m_recover;
  logic             m_bht_en, m_taken, m_jump, m_flush, m_uf;
  logic [LOWER-1:0] m_addr;
  logic [PC_W-1:0]  m_redirect;
  int               m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_recover = 0; m_bht_en = 0; m_taken = 0; m_jump = 0; m_flush = 0; m_uf = 0;
    m_addr = '0; m_redirect = '0; m_cnt = 0;
  endtask

  task automatic model_step(input logic fv, input logic [PC_W-1:0] fpc, input logic fpred,
                            input logic [PC_W-1:0] ftgt, input logic ev, input logic et,
                            input logic ej, input logic [PC_W-1:0] etgt);
    logic [EW-1:0]   e;
    logic [PC_W-1:0] pc, tgt;
    logic            pred, act;
    bit              pop, mis;
    int              sz;
    m_bht_en = 0;
    m_flush  = 0;
    if (m_recover) begin
      m_recover = 0;   // one dead cycle: nothing enters, nothing resolves
    end else begin
      sz  = exp_q.size();
      pop = ev && (sz > 0);
      mis = 0;
      if (ev && sz == 0) m_uf = 1;
      if (pop) begin
        e    = exp_q.pop_front();
        pc   = e[EW-1 -: PC_W];
        pred = e[PC_W];
        tgt  = e[PC_W-1:0];
        act  = et | ej;
        mis  = (pred != act) || (pred && act && tgt != etgt);
        m_bht_en = 1;
        m_addr   = LOWER'(pc >> 2);
        m_taken  = et;
        m_jump   = ej;
        if (mis) begin
          m_flush    = 1;
          m_redirect = act ? etgt : pc + 64'd4;
          if (m_cnt < 65535) m_cnt++;
          exp_q.delete();
          m_recover = 1;
        end
      end
      if (fv && !mis && (sz < DEPTH || pop)) exp_q.push_back({fpc, fpred, ftgt});
    end
  endtask

  task automatic check_outputs();
    check("bht_en", bht_en, m_bht_en);
    if (m_bht_en) begin
      check("bht_write_addr", bht_write_addr, m_addr);
      check("bht_was_taken", bht_was_taken, m_taken);
      check("bht_jumped", bht_jumped, m_jump);
    end
    check("flush", flush, m_flush);
    if (m_flush) check("redirect_pc", redirect_pc, m_redirect);
    check("mispredict_cnt", mispredict_cnt, 64'(m_cnt));
    check("underflow_err", underflow_err, m_uf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q_full"}, q_full, 0);
    check({tag, "_bht_en"}, bht_en, 0);
    check({tag, "_bht_addr"}, bht_write_addr, 0);
    check({tag, "_was_taken"}, bht_was_taken, 0);
    check({tag, "_jumped"}, bht_jumped, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_redirect"}, redirect_pc, 0);
    check({tag, "_cnt"}, mispredict_cnt, 0);
    check({tag, "_underflow"}, underflow_err, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    fetch_valid = 0; fetch_pc = '0; fetch_pred = 0; fetch_target = '0;
    ex_valid = 0; ex_taken = 0; ex_jump = 0; ex_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus: q_full checked mid-cycle, registered outputs after the edge.
  task automatic cycle(input logic fv, input logic [PC_W-1:0] fpc, input logic fpred,
                       input logic [PC_W-1:0] ftgt, input logic ev, input logic et,
                       input logic ej, input logic [PC_W-1:0] etgt);
    fetch_valid = fv; fetch_pc = fpc; fetch_pred = fpred; fetch_target = ftgt;
    ex_valid = ev; ex_taken = et; ex_jump = ej; ex_target = etgt;
    @(negedge clk);
    check("q_full", q_full, (exp_q.size() == DEPTH) ? 1 : 0);
    model_step(fv, fpc, fpred, ftgt, ev, et, ej, etgt);
    @(posedge clk);
    #1;
    check_outputs();
    idle_inputs();
  endtask

  task automatic push_only(input logic [PC_W-1:0] pc, input logic pred, input logic [PC_W-1:0] tgt);
    cycle(1, pc, pred, tgt, 0, 0, 0, '0);
  endtask

  task automatic resolve(input logic et, input logic ej, input logic [PC_W-1:0] tgt);
    cycle(0, '0, 0, '0, 1, et, ej, tgt);
  endtask

  task automatic idle_cycle();
    cycle(0, '0, 0, '0, 0, 0, 0, '0);
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    logic [PC_W-1:0] r;
    r = {$urandom(), $urandom()};
    r[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) r = 64'hFFFF_FFFF_FFFF_FFFC;
    return r;
  endfunction

  function automatic logic [PC_W-1:0] rand_tgt();
    return 64'h100 * PC_W'($urandom_range(1, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    arst_n = 1'b1;
    #2;
    do_reset();

    // 1: correct not-taken prediction
    push_only(64'h40, 0, '0);
    resolve(0, 0, '0);
    check("t1_bht_en", bht_en, 1);
    check("t1_addr", bht_write_addr, 5'h10);
    check("t1_flush", flush, 0);

    // 2: predicted not-taken, actually taken
    push_only(64'h40, 0, '0);
    resolve(1, 0, 64'h80);
    check("t2_flush", flush, 1);
    check("t2_redirect", redirect_pc, 64'h80);
    check("t2_cnt", mispredict_cnt, 1);
    idle_cycle();
    check("t2_flush_pulse", flush, 0);
    check("t2_q_full", q_full, 0);

    // 3: taken as predicted but to a different target
    push_only(64'h10, 1, 64'h20);
    resolve(1, 0, 64'h24);
    check("t3_flush", flush, 1);
    check("t3_redirect", redirect_pc, 64'h24);
    idle_cycle();

    // 4: predicted taken, not taken; younger entries and RECOVER push are discarded
    push_only(64'h100, 1, 64'h200);
    push_only(64'h104, 0, '0);
    push_only(64'h108, 0, '0);
    push_only(64'h10C, 0, '0);
    resolve(0, 0, '0);
    check("t4_redirect", redirect_pc, 64'h104);
    cycle(1, 64'h300, 0, '0, 1, 0, 0, '0);   // RECOVER: push dropped, ex ignored
    check("t4_recover_no_bht", bht_en, 0);
    push_only(64'h54, 0, '0);
    resolve(0, 0, '0);
    check("t4_after_addr", bht_write_addr, 5'h15);
    check("t4_no_underflow", underflow_err, 0);

    // 5: fill, drop on full, push+pop on full keeps order
    push_only(64'h10, 0, '0);
    push_only(64'h14, 0, '0);
    push_only(64'h18, 0, '0);
    push_only(64'h1C, 0, '0);
    check("t5_full", q_full, 1);
    push_only(64'h20, 0, '0);
    cycle(1, 64'h24, 0, '0, 1, 0, 0, '0);
    check("t5_pop_addr", bht_write_addr, 5'h04);
    check("t5_still_full", q_full, 1);
    resolve(0, 0, '0); check("t5_order1", bht_write_addr, 5'h05);
    resolve(0, 0, '0); check("t5_order2", bht_write_addr, 5'h06);
    resolve(0, 0, '0); check("t5_order3", bht_write_addr, 5'h07);
    resolve(0, 0, '0); check("t5_order4", bht_write_addr, 5'h09);

    // 6: underflow, then reset in the middle of a flush
    resolve(0, 0, '0);
    check("t6_no_bht", bht_en, 0);
    check("t6_underflow", underflow_err, 1);
    push_only(64'h80, 0, '0);
    resolve(0, 1, 64'h400);
    check("t6_flush", flush, 1);
    check("t6_jumped", bht_jumped, 1);
    do_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_pc(), 1'($urandom_range(0, 1)), rand_tgt(),
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, rand_tgt());
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
